// File: rtl/rv_fetch.sv
// Instruction fetch stage: issues sequential word reads, pairs each returned word
// with its PC in a small in-order queue and presents the head to decode.
module rv_fetch #(
    parameter logic [31:0] g_reset_vector = 32'h0000_0000,
    parameter int          g_queue_depth  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_stall_i,
    input  logic        f_kill_i,
    input  logic [31:0] f_kill_pc_i,
    output logic        im_rd_o,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o
);

    localparam int PW = (g_queue_depth > 1) ? $clog2(g_queue_depth) : 1;
    localparam int CW = $clog2(g_queue_depth + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] pc_req;
    logic [31:0] q_pc    [g_queue_depth];
    logic [31:0] q_ir    [g_queue_depth];
    logic        q_alloc [g_queue_depth];
    logic        q_ready [g_queue_depth];
    ptr_t        head;
    ptr_t        tail;
    ptr_t        fill;
    cnt_t        count;
    cnt_t        pend;
    cnt_t        drop_cnt;

    logic issue;
    logic pop;
    logic resp_fill;
    logic resp_drop;
    logic credits_ok;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(g_queue_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode handshake: a word transfers in any cycle where f_valid_o is high and
    // f_stall_i is low; while stalled the head and its outputs hold unchanged.
    always_comb begin
        credits_ok = ({1'b0, count} + {1'b0, drop_cnt}) < (CW + 1)'(g_queue_depth);
        issue      = !rst_i && !f_kill_i && credits_ok;
        f_valid_o  = q_alloc[head] && q_ready[head] && !f_kill_i;
        pop        = f_valid_o && !f_stall_i;
        resp_drop  = im_valid_i && (drop_cnt != '0);
        resp_fill  = im_valid_i && (drop_cnt == '0);
    end

    assign im_rd_o   = issue;
    assign im_addr_o = pc_req;
    assign f_ir_o    = q_ir[head];
    assign f_pc_o    = q_pc[head];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_req   <= g_reset_vector;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < g_queue_depth; i++) begin
                q_pc[i]    <= '0;
                q_ir[i]    <= '0;
                q_alloc[i] <= 1'b0;
                q_ready[i] <= 1'b0;
            end
        end else if (f_kill_i) begin
            // Requests still in flight become discards; a response landing now is one of them.
            pc_req   <= {f_kill_pc_i[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= drop_cnt + pend - cnt_t'(im_valid_i);
            for (int i = 0; i < g_queue_depth; i++) begin
                q_pc[i]    <= '0;
                q_ir[i]    <= '0;
                q_alloc[i] <= 1'b0;
                q_ready[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                q_pc[tail]    <= pc_req;
                q_alloc[tail] <= 1'b1;
                q_ready[tail] <= 1'b0;
                tail          <= ptr_inc(tail);
                pc_req        <= pc_req + 32'd4;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (resp_fill) begin
                q_ir[fill]    <= im_data_i;
                q_ready[fill] <= 1'b1;
                fill          <= ptr_inc(fill);
            end
            if (pop) begin
                q_alloc[head] <= 1'b0;
                q_ready[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            count <= count + cnt_t'(issue) - cnt_t'(pop);
            pend  <= pend + cnt_t'(issue) - cnt_t'(resp_fill);
        end
    end

    a_credit_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, count} + {1'b0, drop_cnt}) <= (CW + 1)'(g_queue_depth));

    a_resp_expected : assert property (@(posedge clk_i) disable iff (rst_i)
        im_valid_i |-> ((drop_cnt != '0) || (pend != '0)));

endmodule

// File: tb/tb_rv_fetch.sv
// Directed plus randomised bench for rv_fetch with an in-order memory model and
// a PC scoreboard; every cycle checks issue, address, valid and head contents.
module tb_rv_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        f_stall_i = 1'b0;
    logic        f_kill_i = 1'b0;
    logic [31:0] f_kill_pc_i = '0;
    logic        im_rd_o;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_i = '0;
    logic        im_valid_i = 1'b0;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;

    rv_fetch #(.g_reset_vector(RV), .g_queue_depth(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .f_stall_i  (f_stall_i),
        .f_kill_i   (f_kill_i),
        .f_kill_pc_i(f_kill_pc_i),
        .im_rd_o    (im_rd_o),
        .im_addr_o  (im_addr_o),
        .im_data_i  (im_data_i),
        .im_valid_i (im_valid_i),
        .f_ir_o     (f_ir_o),
        .f_pc_o     (f_pc_o),
        .f_valid_o  (f_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard and memory model state
    logic [31:0] exp_q[$];
    logic [31:0] maddr_q[$];
    int          mdue_q[$];
    logic [31:0] exp_addr = RV;
    int          rdy_n = 0;
    int          drop_m = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          min_d = 1;
    int          max_d = 1;
    bit          prev_rst = 1'b1;
    bit          kill_when_resp = 1'b0;
    int          vec_cnt = 0;
    int          fail_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit stall, input bit kill, input logic [31:0] kpc);
        bit          resp;
        bit          er;
        bit          ev;
        int          due;
        logic [31:0] rdata;
        @(negedge clk_i);
        rst_i       = rst;
        f_stall_i   = stall;
        f_kill_i    = kill;
        f_kill_pc_i = kpc;
        resp        = 1'b0;
        rdata       = $urandom;
        if (!rst && maddr_q.size() > 0 && mdue_q[0] <= cyc) begin
            resp  = 1'b1;
            rdata = mem_word(maddr_q.pop_front());
            void'(mdue_q.pop_front());
        end
        im_valid_i = resp;
        im_data_i  = rdata;
        if (kill_when_resp && resp && !rst) begin
            f_kill_i       = 1'b1;
            kill_when_resp = 1'b0;
        end
        #1;
        er = !f_kill_i && (exp_q.size() + drop_m < DEPTH);
        ev = !f_kill_i && (rdy_n > 0);
        if (!rst) begin
            if (prev_rst) begin
                check("rst_f_ir", f_ir_o, 32'h0);
                check("rst_f_pc", f_pc_o, 32'h0);
                check("rst_im_addr", im_addr_o, RV);
            end
            check("im_rd", {31'b0, im_rd_o}, {31'b0, er});
            if (er) check("im_addr", im_addr_o, exp_addr);
            check("f_valid", {31'b0, f_valid_o}, {31'b0, ev});
            if (ev) begin
                check("f_pc", f_pc_o, exp_q[0]);
                check("f_ir", f_ir_o, mem_word(exp_q[0]));
            end
        end
        if (rst) begin
            exp_q.delete();
            maddr_q.delete();
            mdue_q.delete();
            rdy_n    = 0;
            drop_m   = 0;
            last_due = 0;
            exp_addr = RV;
        end else if (f_kill_i) begin
            drop_m   = drop_m + (exp_q.size() - rdy_n) - (resp ? 1 : 0);
            exp_q.delete();
            rdy_n    = 0;
            exp_addr = {f_kill_pc_i[31:2], 2'b00};
        end else begin
            if (resp) begin
                if (drop_m > 0) drop_m--;
                else rdy_n++;
            end
            if (ev && !stall) begin
                void'(exp_q.pop_front());
                rdy_n--;
            end
            if (er) begin
                exp_q.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
        end
        if (!rst && im_rd_o === 1'b1) begin
            due = cyc + $urandom_range(max_d, min_d);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            maddr_q.push_back(im_addr_o);
            mdue_q.push_back(due);
        end
        prev_rst = rst;
        cyc++;
    endtask

    initial begin
        // Reset, then a 1-cycle memory with no stall
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        min_d = 1; max_d = 1;
        repeat (20) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall mid-stream for 5 cycles; head must hold while credits run out
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Kill with requests in flight on a slower memory
        min_d = 3; max_d = 3;
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (12) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Kill coinciding with a response, misaligned target
        kill_when_resp = 1'b1;
        repeat (20) step(1'b0, 1'b0, 1'b0, 32'h0000_0103);
        check("kill_on_resp_fired", {31'b0, kill_when_resp}, 32'h0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Back-to-back kills, kill during stall, and PC wrap at the top of memory
        min_d = 1; max_d = 2;
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9);
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);

        // Random wait states, stalls and kills
        min_d = 1; max_d = 4;
        for (int i = 0; i < 1500; i++) begin
            step(1'b0, ($urandom_range(99, 0) < 25), ($urandom_range(99, 0) < 3),
                 $urandom_range(32'h0000_FFFF, 0));
        end

        // Reset mid-stream with outstanding requests, then restart
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (30) step(1'b0, ($urandom_range(99, 0) < 20), 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
Instruction fetch stage of the uRV pipeline, directly upstream of the decode stage. Generates sequential PCs and issues pipelined reads to the instruction memory. Pairs each returned word with its PC in a small in-order queue, then presents {f_ir_o, f_pc_o, f_valid_o} to decode. Honours the decode stall and redirects on kill/branch, discarding responses still in flight.

Parameters:
g_reset_vector, 32'h0000_0000, PC of the first fetch after reset (bits [1:0] must be 0)
g_queue_depth, 2, fetch queue entries = max outstanding + buffered words (legal 2..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
f_stall_i  in  1  decode not accepting this cycle (tied to decode stall)
f_kill_i  in  1  redirect request from execute
f_kill_pc_i  in  32  redirect target PC
im_rd_o  out  1  instruction read request; one request per cycle when high
im_addr_o  out  32  read address, word aligned
im_data_i  in  32  returned instruction word
im_valid_i  in  1  im_data_i valid; responses in order, at least 1 cycle after request
f_ir_o  out  32  instruction to decode
f_pc_o  out  32  PC of f_ir_o
f_valid_o  out  1  f_ir_o/f_pc_o valid

Behaviour:
- Reset: im_rd_o=0, im_addr_o=g_reset_vector, f_valid_o=0, f_ir_o=0, f_pc_o=0. Queue empty, drop_cnt=0. im_valid_i is ignored during reset. The memory shares rst_i, so no stale responses arrive afterwards.
- State: pc_req (next fetch PC); circular queue of g_queue_depth entries {pc, ir, alloc, ready} with head/tail pointers and count; drop_cnt (responses to discard).
- Issue: im_rd_o = !rst_i && !f_kill_i && (count + drop_cnt < g_queue_depth).
  - count and drop_cnt are the registered values; a same-cycle pop does not free a credit.
  - On issue: im_addr_o = pc_req; an entry is allocated at the tail with pc=pc_req and ready=0; pc_req += 4 (32-bit wrap).
- Response: on im_valid_i with drop_cnt>0, drop_cnt decrements and the data is discarded. Otherwise im_data_i is written to the oldest allocated, not-ready entry and ready is set.
- Output: f_valid_o = head.alloc && head.ready && !f_kill_i. f_ir_o and f_pc_o are driven from the head entry registers.
  - Pop when f_valid_o && !f_stall_i.
  - Latency: request at cycle N, response at N+1, f_valid_o at N+2.
- Stall: while f_stall_i is high, head and outputs hold stable. Issue continues until credits run out. Responses keep filling allocated entries; nothing is lost.
- Kill, cycle K:
  - No issue; f_valid_o=0.
  - At K+1: pc_req = {f_kill_pc_i[31:2], 2'b00}; all entries cleared.
  - drop_cnt = drop_cnt + (allocated-not-ready entries) − (1 if im_valid_i in cycle K). A response arriving in cycle K is discarded.
  - First redirected request is issued at K+1.
- Kill during stall: kill wins; the queue is flushed regardless of f_stall_i.
- Back-to-back kills: the second redirect overrides the first. drop_cnt accumulates correctly because requests issued between the kills are counted as in flight.
- Full queue with a simultaneous response and pop: both take effect; count decrements by one.
- Invariant: count + drop_cnt ≤ g_queue_depth at all times. An assertion in simulation flags any violation or any response with no pending entry.

Test Plan:
- Reset release, memory with 1-cycle latency, no stall → im_addr_o 0x0,0x4,0x8… on consecutive cycles; f_valid_o first high 2 cycles after the first request, with f_pc_o=0x0 and f_ir_o equal to mem[0]; thereafter one instruction per cycle.
- f_stall_i high for 5 cycles mid-stream (depth 2) → im_rd_o drops after 2 credits are used; f_pc_o/f_ir_o hold; after release, PCs continue with no gap or duplicate.
- f_kill_i with f_kill_pc_i=0x100 while 2 requests are in flight → both responses discarded; next im_addr_o=0x100; first f_valid_o shows f_pc_o=0x100.
- Kill in the same cycle as im_valid_i, and a kill with target 0x103 → that response is dropped; fetch resumes at 0x100.
- Random memory wait states (im_valid_i delayed 1–4 cycles) combined with random stalls and kills → decode sees a strictly sequential PC stream between redirects, every f_ir_o equals mem[f_pc_o>>2], and the invariant assertion never fires.
- rst_i asserted mid-stream with entries outstanding → next cycle all outputs are at reset values; fetch restarts at g_reset_vector.
